// File: rtl/sdram_pkg.sv
// Shared types for the sdram requester channels.
// Holds the word bundle handed to the controller and the request FSM states.
package sdram_pkg;

    typedef struct packed {
        logic [26:1] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } ch_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } wr_state_t;

    localparam int unsigned CH_WORD_W = $bits(ch_word_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a first-word fall-through head.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_dl_writer.sv
// Write-channel master: packs the loader byte stream into 16-bit words
// and feeds them to the sdram controller through an edge-triggered req/ready.
module sdram_dl_writer
    import sdram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [25:0] BASE_WORD  = 26'h0,
    parameter bit          SWAP_BYTES = 1'b0,
    parameter logic [15:0] TIMEOUT    = 16'd1023
) (
    input  logic        clk,
    input  logic        init,
    input  logic        dl_wr,
    input  logic [26:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        dl_done,
    output logic        dl_wait,
    output logic        busy,
    output logic        err,
    output logic [25:0] ch3_addr,
    output logic [15:0] ch3_din,
    output logic [1:0]  ch3_be,
    output logic        ch3_rnw,
    output logic        ch3_req,
    input  logic        ch3_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);

    wr_state_t state;
    wr_state_t state_nxt;

    logic     pend_v;
    logic     pend_v_nxt;
    ch_word_t pend;
    ch_word_t pend_nxt;
    logic     flush_req;
    logic     flush_nxt;

    logic     push;
    ch_word_t push_word;
    logic     viol;
    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_full;
    logic     fifo_empty;
    ch_word_t fifo_head;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_nxt;

    logic [25:0] wa;
    logic        lane_hi;
    logic [15:0] lane_mask;
    ch_word_t    single;
    ch_word_t    merged;

    ch_word_t    out_word;
    logic        load;
    logic [15:0] tcnt;
    logic        tmo_hit;

    sync_fifo #(
        .WIDTH (CH_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (init),
        .push  (fifo_push),
        .din   (push_word),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        wa          = dl_addr[26:1] + BASE_WORD;
        lane_hi     = dl_addr[0] ^ SWAP_BYTES;
        lane_mask   = lane_hi ? 16'hFF00 : 16'h00FF;
        single.addr = wa;
        single.data = lane_hi ? {dl_data, 8'h00} : {8'h00, dl_data};
        single.be   = lane_hi ? 2'b10 : 2'b01;
        merged.addr = wa;
        merged.data = (pend.data & ~lane_mask) | single.data;
        merged.be   = pend.be | single.be;
    end

    always_comb begin
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        flush_nxt  = flush_req;
        push       = 1'b0;
        push_word  = pend;
        if (dl_wr) begin
            unique case (1'b1)
                !pend_v: begin
                    pend_nxt   = single;
                    pend_v_nxt = 1'b1;
                end
                pend_v && (pend.addr == wa): begin
                    pend_nxt = merged;
                    if (merged.be == 2'b11) begin
                        push       = 1'b1;
                        push_word  = merged;
                        pend_v_nxt = 1'b0;
                    end
                end
                pend_v && (pend.addr != wa): begin
                    push      = 1'b1;
                    push_word = pend;
                    pend_nxt  = single;
                end
            endcase
        end
        // Flush takes the post-update pending word so a same-cycle byte is kept.
        if (flush_req && !push && !fifo_full) begin
            if (pend_v_nxt) begin
                push       = 1'b1;
                push_word  = pend_nxt;
                pend_v_nxt = 1'b0;
            end
            flush_nxt = 1'b0;
        end
        if (dl_done) begin
            flush_nxt = 1'b1;
        end
    end

    assign viol      = dl_wr && dl_wait;
    assign fifo_push = push && !viol && !fifo_full;
    assign count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ch3_ready) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign tmo_hit = (state == ST_REQ) && !ch3_ready && (tcnt == TIMEOUT);

    always_ff @(posedge clk) begin
        if (init) begin
            state     <= ST_IDLE;
            pend_v    <= 1'b0;
            pend      <= '0;
            flush_req <= 1'b0;
            out_word  <= '0;
            tcnt      <= '0;
            err       <= 1'b0;
            dl_wait   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend_v    <= pend_v_nxt;
            pend      <= pend_nxt;
            flush_req <= flush_nxt;
            dl_wait   <= (count_nxt >= WAIT_LVL);
            if (load) begin
                out_word <= fifo_head;
                tcnt     <= '0;
            end else if (state == ST_REQ && !ch3_ready && !tmo_hit) begin
                tcnt <= tcnt + 16'd1;
            end
            if (viol || tmo_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign ch3_req  = (state == ST_REQ);
    assign ch3_rnw  = 1'b0;
    assign ch3_addr = out_word.addr;
    assign ch3_din  = out_word.data;
    assign ch3_be   = out_word.be;
    assign busy     = pend_v | flush_req | !fifo_empty | (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_dl_writer.sv
// Directed bench for sdram_dl_writer with a small controller model.
// Instance a has BASE_WORD=0, TIMEOUT=40; instance b has BASE_WORD=all ones.
module tb_sdram_dl_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        init;
    logic        dl_wr;
    logic        dl_done;
    logic        sel2;
    logic [26:0] dl_addr;
    logic [7:0]  dl_data;

    logic wr1, done1, wr2, done2;
    assign wr1   = dl_wr & ~sel2;
    assign done1 = dl_done & ~sel2;
    assign wr2   = dl_wr & sel2;
    assign done2 = dl_done & sel2;

    logic        dl_wait, busy, err, ch3_rnw, ch3_req;
    logic [25:0] ch3_addr;
    logic [15:0] ch3_din;
    logic [1:0]  ch3_be;
    logic        ch3_ready = 1'b0;

    logic        b_wait, b_busy, b_err, b_rnw, b_req;
    logic [25:0] b_addr;
    logic [15:0] b_din;
    logic [1:0]  b_be;
    logic        b_ready = 1'b0;

    sdram_dl_writer #(
        .FIFO_DEPTH (4),
        .BASE_WORD  (26'h0),
        .SWAP_BYTES (1'b0),
        .TIMEOUT    (16'd40)
    ) dut_a (
        .clk       (clk),
        .init      (init),
        .dl_wr     (wr1),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_done   (done1),
        .dl_wait   (dl_wait),
        .busy      (busy),
        .err       (err),
        .ch3_addr  (ch3_addr),
        .ch3_din   (ch3_din),
        .ch3_be    (ch3_be),
        .ch3_rnw   (ch3_rnw),
        .ch3_req   (ch3_req),
        .ch3_ready (ch3_ready)
    );

    sdram_dl_writer #(
        .FIFO_DEPTH (4),
        .BASE_WORD  (26'h3FFFFFF),
        .SWAP_BYTES (1'b0),
        .TIMEOUT    (16'd1023)
    ) dut_b (
        .clk       (clk),
        .init      (init),
        .dl_wr     (wr2),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_done   (done2),
        .dl_wait   (b_wait),
        .busy      (b_busy),
        .err       (b_err),
        .ch3_addr  (b_addr),
        .ch3_din   (b_din),
        .ch3_be    (b_be),
        .ch3_rnw   (b_rnw),
        .ch3_req   (b_req),
        .ch3_ready (b_ready)
    );

    // Controller model for instance a: logs each rising req, answers after a delay.
    int          n_req = 0;
    logic [25:0] log_addr [64];
    logic [15:0] log_din  [64];
    logic [1:0]  log_be   [64];
    logic        log_rnw  [64];
    int          log_gap  [64];
    logic        req_q = 1'b0;
    logic        armed = 1'b0;
    int          wait_cnt = 0;
    int          low_run = 0;
    int          rdy_delay = 0;
    logic        rdy_en = 1'b1;
    logic        mon = 1'b0;
    int          exp_cnt = 0;

    always @(posedge clk) begin
        req_q     <= ch3_req;
        ch3_ready <= 1'b0;
        low_run   <= ch3_req ? 0 : low_run + 1;
        if (init) begin
            armed <= 1'b0;
        end else if (ch3_req && !req_q) begin
            if (n_req < 64) begin
                log_addr[n_req] <= ch3_addr;
                log_din[n_req]  <= ch3_din;
                log_be[n_req]   <= ch3_be;
                log_rnw[n_req]  <= ch3_rnw;
                log_gap[n_req]  <= low_run;
            end
            n_req    <= n_req + 1;
            wait_cnt <= rdy_delay;
            armed    <= rdy_en;
        end else if (armed) begin
            if (wait_cnt == 0) begin
                ch3_ready <= 1'b1;
                armed     <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt - 1;
            end
        end
        if (mon) begin
            exp_cnt <= exp_cnt + ((wr1 && dl_addr[0]) ? 1 : 0) - (ch3_ready ? 1 : 0);
        end else begin
            exp_cnt <= 0;
        end
    end

    int          b_n = 0;
    logic        b_req_q = 1'b0;
    logic        b_armed = 1'b0;
    int          b_cnt = 0;
    logic [25:0] b_addr_l = '0;
    logic [15:0] b_din_l = '0;
    logic [1:0]  b_be_l = '0;

    always @(posedge clk) begin
        b_req_q <= b_req;
        b_ready <= 1'b0;
        if (init) begin
            b_armed <= 1'b0;
        end else if (b_req && !b_req_q) begin
            b_addr_l <= b_addr;
            b_din_l  <= b_din;
            b_be_l   <= b_be;
            b_n      <= b_n + 1;
            b_cnt    <= 2;
            b_armed  <= 1'b1;
        end else if (b_armed) begin
            if (b_cnt == 0) begin
                b_ready <= 1'b1;
                b_armed <= 1'b0;
            end else begin
                b_cnt <= b_cnt - 1;
            end
        end
    end

    int   n_chk = 0;
    int   n_fail = 0;
    logic saw_wait = 1'b0;
    int   base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (mon) begin
            if (dl_wait) saw_wait = 1'b1;
            chk("dl_wait_lvl", 32'(dl_wait), 32'(exp_cnt >= 3));
        end
    endtask

    task automatic wr(input logic [26:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick;
        dl_wr   = 1'b0;
    endtask

    task automatic done;
        dl_done = 1'b1;
        tick;
        dl_done = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int lim);
        int k = 0;
        while (!ch3_ready && k < lim) begin
            tick;
            k++;
        end
        chk(tag, 32'(ch3_ready), 32'h1);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (busy && k < lim) begin
            tick;
            k++;
        end
        chk(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init = 1'b1; dl_wr = 1'b0; dl_done = 1'b0; sel2 = 1'b0;
        dl_addr = '0; dl_data = '0;
        repeat (3) tick;
        chk("rst_req",  32'(ch3_req),  32'h0);
        chk("rst_addr", 32'(ch3_addr), 32'h0);
        chk("rst_din",  32'(ch3_din),  32'h0);
        chk("rst_be",   32'(ch3_be),   32'h0);
        chk("rst_wait", 32'(dl_wait),  32'h0);
        chk("rst_busy", 32'(busy),     32'h0);
        chk("rst_err",  32'(err),      32'h0);
        chk("rst_rnw",  32'(ch3_rnw),  32'h0);
        init = 1'b0;
        tick;
        chk("post_rst_busy", 32'(busy), 32'h0);

        // Aligned pair forms one full word.
        wr(27'd0, 8'h11);
        wr(27'd1, 8'h22);
        wait_ready("t1_ready", 50);
        chk("t1_nreq", 32'(n_req), 32'd1);
        chk("t1_addr", 32'(log_addr[0]), 32'h0);
        chk("t1_din",  32'(log_din[0]),  32'h2211);
        chk("t1_be",   32'(log_be[0]),   32'h3);
        chk("t1_rnw",  32'(log_rnw[0]),  32'h0);
        tick;
        chk("t1_gap_req",  32'(ch3_req), 32'h0);
        chk("t1_gap_busy", 32'(busy),    32'h1);
        tick;
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // Lone high-lane byte waits for dl_done.
        base = n_req;
        wr(27'd5, 8'hAB);
        repeat (4) tick;
        chk("t2_pend_busy", 32'(busy),  32'h1);
        chk("t2_no_req",    32'(n_req), 32'(base));
        done;
        wait_ready("t2_ready", 50);
        chk("t2_addr", 32'(log_addr[base]),      32'h2);
        chk("t2_dhi",  32'(log_din[base][15:8]), 32'hAB);
        chk("t2_be",   32'(log_be[base]),        32'h2);
        tick;
        chk("t2_gap_req",  32'(ch3_req), 32'h0);
        chk("t2_gap_busy", 32'(busy),    32'h1);
        tick;
        chk("t2_idle_busy", 32'(busy), 32'h0);

        // Word change pushes the old partial word; done flushes the new one.
        base = n_req;
        wr(27'd4, 8'h31);
        wr(27'd9, 8'h42);
        done;
        wait_idle("t3_idle", 100);
        chk("t3_nreq",  32'(n_req),              32'(base + 2));
        chk("t3_addr0", 32'(log_addr[base]),     32'h2);
        chk("t3_be0",   32'(log_be[base]),       32'h1);
        chk("t3_din0",  32'(log_din[base]),      32'h0031);
        chk("t3_addr1", 32'(log_addr[base + 1]), 32'h4);
        chk("t3_be1",   32'(log_be[base + 1]),   32'h2);
        chk("t3_din1",  32'(log_din[base + 1]),  32'h4200);

        // Slow controller with a 16-byte stream exercises backpressure.
        base = n_req;
        rdy_delay = 20;
        mon = 1'b1;
        tick;
        for (int i = 0; i < 16; i++) begin
            int k = 0;
            while (dl_wait && k < 200) begin
                tick;
                k++;
            end
            chk("t4_stall", 32'(dl_wait), 32'h0);
            wr(27'(16 + i), 8'(8'h50 + i));
        end
        wait_idle("t4_idle", 1000);
        mon = 1'b0;
        chk("t4_saw_wait", 32'(saw_wait), 32'h1);
        chk("t4_err",      32'(err),      32'h0);
        chk("t4_nreq",     32'(n_req),    32'(base + 8));
        for (int j = 0; j < 8; j++) begin
            chk("t4_addr", 32'(log_addr[base + j]), 32'(8 + j));
            chk("t4_din",  32'(log_din[base + j]),
                32'({8'(8'h51 + 2 * j), 8'(8'h50 + 2 * j)}));
            chk("t4_be",   32'(log_be[base + j]), 32'h3);
        end
        for (int j = 1; j < 8; j++) begin
            chk("t4_gap", 32'(log_gap[base + j]), 32'd2);
        end
        rdy_delay = 0;

        // Word address wraps past the top of the 26-bit space.
        sel2 = 1'b1;
        wr(27'd2, 8'h5A);
        wr(27'd3, 8'hA5);
        sel2 = 1'b0;
        begin
            int k = 0;
            while (b_n == 0 && k < 50) begin
                tick;
                k++;
            end
        end
        chk("t5_n",    32'(b_n),      32'd1);
        chk("t5_addr", 32'(b_addr_l), 32'h0);
        chk("t5_be",   32'(b_be_l),   32'h3);
        chk("t5_din",  32'(b_din_l),  32'hA55A);
        repeat (10) tick;
        chk("t5_busy", 32'(b_busy), 32'h0);
        chk("t5_err",  32'(b_err),  32'h0);
        chk("t5_wait", 32'(b_wait), 32'h0);
        chk("t5_rnw",  32'(b_rnw),  32'h0);

        // Withheld ready: sticky err, req held, then init mid-request.
        base = n_req;
        rdy_en = 1'b0;
        wr(27'd32, 8'h01);
        wr(27'd33, 8'h02);
        begin
            int k = 0;
            while (!ch3_req && k < 20) begin
                tick;
                k++;
            end
        end
        chk("t6_req_up", 32'(ch3_req), 32'h1);
        repeat (30) tick;
        chk("t6_err_early", 32'(err), 32'h0);
        repeat (20) tick;
        chk("t6_err",      32'(err),      32'h1);
        chk("t6_req_held", 32'(ch3_req),  32'h1);
        chk("t6_addr",     32'(ch3_addr), 32'h10);
        init = 1'b1;
        tick;
        chk("t6_init_req",  32'(ch3_req), 32'h0);
        chk("t6_init_busy", 32'(busy),    32'h0);
        chk("t6_init_err",  32'(err),     32'h0);
        chk("t6_init_wait", 32'(dl_wait), 32'h0);
        init = 1'b0;
        rdy_en = 1'b1;
        repeat (10) tick;
        chk("t6_no_new_req", 32'(n_req), 32'(base + 1));
        chk("t6_idle_busy",  32'(busy),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
